// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a single-port, 1-cycle-latency RAM.
// Accepts a valid/ready push stream, stores words in the RAM, and presents the
// head word in a registered pop port. An empty FIFO bypasses the RAM and loads
// the output register directly. Capacity is 2^N RAM words plus the output word.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push_valid/ready/data producer side
//   pop_valid/ready/data  consumer side (pop_data registered)
//   count                 words held (RAM entries + output register)
//   ram_we/adr/din        RAM write/address/data, combinational
//   ram_dout              RAM read data, valid one clock after the address
module ram_fifo_ctrl #(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [M-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [M-1:0] pop_data,
  output logic [N+1:0] count,
  output logic         ram_we,
  output logic [N-1:0] ram_adr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout
);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t       state;
  logic [N-1:0] wr_ptr;
  logic [N-1:0] rd_ptr;
  logic [N:0]   ram_cnt;
  logic         out_valid;
  logic [M-1:0] out_data;

  logic pop;
  logic out_free;
  logic fetch_issue;
  logic push;
  logic bypass;
  logic ram_full;
  logic ram_empty;

  always_comb begin
    // ram_cnt never exceeds 2^N, so its MSB alone flags a full RAM
    ram_full    = ram_cnt[N];
    ram_empty   = (ram_cnt == '0);
    pop         = out_valid & pop_ready;
    out_free    = ~out_valid | pop;
    // a fetch owns the single RAM port, so it blocks pushes that cycle
    fetch_issue = (state == IDLE) & ~ram_empty & out_free;
    push_ready  = rst_n & ~ram_full & ~fetch_issue;
    push        = push_valid & push_ready;
    bypass      = push & (state == IDLE) & ram_empty & out_free;
    ram_we      = push & ~bypass;
    ram_adr     = fetch_issue ? rd_ptr : wr_ptr;
    ram_din     = push_data;
    pop_valid   = out_valid;
    pop_data    = out_data;
    count       = (N+2)'(ram_cnt) + (N+2)'(out_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // fetch_issue is only ever set in IDLE, and RD_WAIT lasts one cycle
      state <= fetch_issue ? RD_WAIT : IDLE;

      // fetch and RAM write are mutually exclusive (push_ready excludes fetch)
      if (fetch_issue) begin
        rd_ptr  <= rd_ptr + 1'b1;
        ram_cnt <= ram_cnt - 1'b1;
      end else if (ram_we) begin
        wr_ptr  <= wr_ptr + 1'b1;
        ram_cnt <= ram_cnt + 1'b1;
      end

      // out_valid is always clear in RD_WAIT, so no pop can collide with the
      // capture; a fetch issued alongside a pop leaves the register empty
      // for the wait cycle
      if (state == RD_WAIT) begin
        out_valid <= 1'b1;
        out_data  <= ram_dout;
      end else if (bypass) begin
        out_valid <= 1'b1;
        out_data  <= push_data;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
  localparam int N = 4;
  localparam int M = 32;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         push_valid = 1'b0;
  logic         push_ready;
  logic [M-1:0] push_data = '0;
  logic         pop_valid;
  logic         pop_ready = 1'b0;
  logic [M-1:0] pop_data;
  logic [N+1:0] count;
  logic         ram_we;
  logic [N-1:0] ram_adr;
  logic [M-1:0] ram_din;
  logic [M-1:0] ram_dout;

  int errors = 0;
  int checks = 0;

  ram_fifo_ctrl #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // single-port RAM with one clock of read latency
  logic [M-1:0] mem [D];
  always @(posedge clk) begin
    if (ram_we) mem[ram_adr] <= ram_din;
    ram_dout <= mem[ram_adr];
  end

  // reference model: words held as a queue plus output slot and in-flight slot
  logic [M-1:0] mq[$];
  bit           m_outv;
  logic [M-1:0] m_outd;
  bit           m_fly;
  logic [M-1:0] m_flyd;
  int           m_wr, m_rd;
  bit           e_pop, e_fetch, e_ready, e_push, e_bypass;
  logic [N-1:0] e_adr;
  logic [M-1:0] sb[$];

  function automatic void model_reset();
    mq.delete();
    m_outv = 0; m_outd = '0; m_fly = 0; m_wr = 0; m_rd = 0;
  endfunction

  function automatic void model_comb();
    e_pop    = m_outv && pop_ready;
    e_fetch  = !m_fly && mq.size() > 0 && (!m_outv || e_pop);
    e_ready  = mq.size() < D && !e_fetch;
    e_push   = push_valid && e_ready;
    e_bypass = e_push && !m_fly && mq.size() == 0 && (!m_outv || e_pop);
    e_adr    = e_fetch ? N'(m_rd) : N'(m_wr);
  endfunction

  function automatic void model_edge();
    if (m_fly) begin
      m_outv = 1; m_outd = m_flyd; m_fly = 0;
    end else if (e_bypass) begin
      m_outv = 1; m_outd = push_data;
    end else if (e_pop) begin
      m_outv = 0;
    end
    if (e_fetch) begin
      m_fly = 1; m_flyd = mq.pop_front(); m_rd = (m_rd + 1) % D;
    end
    if (e_push && !e_bypass) begin
      mq.push_back(push_data); m_wr = (m_wr + 1) % D;
    end
  endfunction

  task automatic half();
    @(negedge clk);
    model_comb();
  endtask

  task automatic fin();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    push_valid = 1'b1;
    #1;
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL rst_push_ready got %b exp 0", push_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
    checks++; if (ram_adr !== '0) begin errors++; $display("FAIL rst_ram_adr got %h exp 0", ram_adr); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid got %b exp 0", pop_valid); end
    checks++; if (pop_data !== '0) begin errors++; $display("FAIL rst_pop_data got %h exp 0", pop_data); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    push_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_comb();
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL first_ready got %b exp 1", push_ready); end
    fin();
  endtask

  task automatic test_bypass();
    push_valid = 1'b1; push_data = 32'hA; pop_ready = 1'b0;
    half();
    checks++; if (push_ready !== e_ready) begin errors++; $display("FAIL byp_ready got %b exp %b", push_ready, e_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL byp_ram_we got %b exp 0", ram_we); end
    fin();
    push_valid = 1'b0;
    checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL byp_pop_valid got %b exp 1", pop_valid); end
    checks++; if (pop_data !== 32'hA) begin errors++; $display("FAIL byp_pop_data got %h exp 0000000a", pop_data); end
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL byp_count got %0d exp 1", count); end
    pop_ready = 1'b1;
    half();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL byp_pop_ram_we got %b exp 0", ram_we); end
    fin();
    pop_ready = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL byp_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_order();
    logic [M-1:0] words [4];
    int k;
    words = '{32'hA, 32'hFA12, 32'hFFFF, 32'hFFFFFFFF};
    pop_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_data = words[i];
      half();
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL ord_ready[%0d] got %b exp 1", i, push_ready); end
      checks++; if (ram_we !== (i != 0)) begin errors++; $display("FAIL ord_we[%0d] got %b exp %b", i, ram_we, i != 0); end
      if (i != 0) begin
        checks++; if (ram_adr !== N'(i - 1)) begin errors++; $display("FAIL ord_adr[%0d] got %0d exp %0d", i, ram_adr, i - 1); end
      end
      fin();
    end
    push_valid = 1'b0;
    checks++; if (count !== 6'd4) begin errors++; $display("FAIL ord_count got %0d exp 4", count); end
    pop_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 16 && k < 4; cyc++) begin
      half();
      checks++; if (pop_valid !== m_outv) begin errors++; $display("FAIL ord_pop_valid cyc=%0d got %b exp %b", cyc, pop_valid, m_outv); end
      if (pop_valid === 1'b1) begin
        checks++; if (pop_data !== words[k]) begin errors++; $display("FAIL ord_pop_data[%0d] got %h exp %h", k, pop_data, words[k]); end
        k++;
      end
      fin();
    end
    pop_ready = 1'b0;
    checks++; if (k != 4) begin errors++; $display("FAIL ord_pops got %0d exp 4", k); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL ord_final_count got %0d exp 0", count); end
  endtask

  task automatic test_fill();
    int acc, got;
    logic [M-1:0] base;
    for (int unsigned rep = 0; rep < 2; rep++) begin
      base = rep * 32'h1000;
      pop_ready = 1'b0; acc = 0;
      for (int unsigned i = 0; i < 18; i++) begin
        push_valid = 1'b1; push_data = base + i;
        half();
        checks++; if (push_ready !== e_ready) begin errors++; $display("FAIL fill_ready[%0d] got %b exp %b", i, push_ready, e_ready); end
        if (push_ready === 1'b1) acc++;
        fin();
      end
      push_valid = 1'b0;
      checks++; if (acc != 17) begin errors++; $display("FAIL fill_accepted got %0d exp 17", acc); end
      checks++; if (count !== 6'd17) begin errors++; $display("FAIL fill_count got %0d exp 17", count); end
      checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", push_ready); end
      pop_ready = 1'b1; got = 0;
      for (int cyc = 0; cyc < 60 && got < 17; cyc++) begin
        half();
        checks++; if (pop_valid !== m_outv) begin errors++; $display("FAIL fill_pop_valid cyc=%0d got %b exp %b", cyc, pop_valid, m_outv); end
        checks++; if (ram_adr !== e_adr) begin errors++; $display("FAIL fill_adr cyc=%0d got %0d exp %0d", cyc, ram_adr, e_adr); end
        if (pop_valid === 1'b1) begin
          checks++; if (pop_data !== base + got) begin errors++; $display("FAIL fill_pop_data[%0d] got %h exp %h", got, pop_data, base + got); end
          got++;
        end
        fin();
      end
      checks++; if (got != 17) begin errors++; $display("FAIL fill_pops got %0d exp 17", got); end
      for (int unsigned i = 0; i < 3; i++) begin
        half();
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL fill_extra_pop got %b exp 0 data %h", pop_valid, pop_data); end
        fin();
      end
      checks++; if (count !== 6'd0) begin errors++; $display("FAIL fill_drain_count got %0d exp 0", count); end
      pop_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] exp;
    sb.delete();
    for (int unsigned cyc = 0; cyc < 340; cyc++) begin
      if (cyc < 40) begin
        push_valid = 1'b1; pop_ready = 1'b1;
      end else if (cyc < 190) begin
        push_valid = ($urandom_range(0, 3) != 0); pop_ready = ($urandom_range(0, 3) == 0);
      end else begin
        push_valid = ($urandom_range(0, 3) == 0); pop_ready = ($urandom_range(0, 3) != 0);
      end
      push_data = $urandom;
      half();
      checks++; if (push_ready !== e_ready) begin errors++; $display("FAIL b2b_ready cyc=%0d got %b exp %b", cyc, push_ready, e_ready); end
      checks++; if (ram_we !== (e_push && !e_bypass)) begin errors++; $display("FAIL b2b_we cyc=%0d got %b exp %b", cyc, ram_we, e_push && !e_bypass); end
      checks++; if (ram_adr !== e_adr) begin errors++; $display("FAIL b2b_adr cyc=%0d got %0d exp %0d", cyc, ram_adr, e_adr); end
      checks++; if (pop_valid !== m_outv) begin errors++; $display("FAIL b2b_pop_valid cyc=%0d got %b exp %b", cyc, pop_valid, m_outv); end
      if (m_outv) begin
        checks++; if (pop_data !== m_outd) begin errors++; $display("FAIL b2b_pop_data cyc=%0d got %h exp %h", cyc, pop_data, m_outd); end
      end
      checks++; if (count !== (N+2)'(mq.size() + int'(m_outv))) begin errors++; $display("FAIL b2b_count cyc=%0d got %0d exp %0d", cyc, count, mq.size() + int'(m_outv)); end
      checks++; if (count > 6'd17) begin errors++; $display("FAIL b2b_count_max cyc=%0d got %0d exp <=17", cyc, count); end
      checks++; if (ram_we === 1'b1 && e_fetch) begin errors++; $display("FAIL b2b_we_with_fetch cyc=%0d got we=1 exp we=0", cyc); end
      if (push_valid && push_ready === 1'b1) sb.push_back(push_data);
      if (pop_ready && pop_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_order cyc=%0d got %h exp nothing", cyc, pop_data);
        end else begin
          exp = sb.pop_front();
          if (pop_data !== exp) begin errors++; $display("FAIL b2b_order cyc=%0d got %h exp %h", cyc, pop_data, exp); end
        end
      end
      fin();
    end
    push_valid = 1'b0; pop_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && count !== 6'd0; cyc++) begin
      half();
      if (pop_valid === 1'b1) begin
        checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : ~pop_data;
        if (pop_data !== exp) begin errors++; $display("FAIL b2b_drain_order got %h exp %h", pop_data, exp); end
      end
      fin();
    end
    pop_ready = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL b2b_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid_fetch();
    pop_ready = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      push_valid = 1'b1; push_data = 32'h100 + i;
      half(); fin();
    end
    push_valid = 1'b0; pop_ready = 1'b1;
    half(); fin();
    pop_ready = 1'b0;
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL mid_count_before got %0d exp 5", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL mid_pop_valid got %b exp 0", pop_valid); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_ram_we got %b exp 0", ram_we); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", push_ready); end
    model_reset();
    @(negedge clk);
    push_valid = 1'b1; push_data = 32'hF; pop_ready = 1'b0;
    rst_n = 1'b1;
    model_comb();
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready got %b exp 1", push_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_after_we got %b exp 0", ram_we); end
    fin();
    push_valid = 1'b0;
    checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL mid_byp_valid got %b exp 1", pop_valid); end
    checks++; if (pop_data !== 32'hF) begin errors++; $display("FAIL mid_byp_data got %h exp 0000000f", pop_data); end
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL mid_byp_count got %0d exp 1", count); end
    pop_ready = 1'b1;
    half(); fin();
    pop_ready = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL mid_final_count got %0d exp 0", count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bypass();
    test_order();
    test_fill();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

FIFO controller placed directly upstream of `ram_top`: it turns a valid/ready push stream into `we`/`adr`/`din` writes on the single-port RAM and reads words back out through `dout` into a registered pop port. It adds ordering, full/empty tracking, a one-word output register and an empty-FIFO bypass. Depth is 2^N RAM words plus one output-register word.

## Interface
- `N`, 4, RAM address width; RAM depth 2^N
- `M`, 32, data width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `push_valid`  in  1  producer has a word
- `push_ready`  out  1  controller accepts the word this cycle
- `push_data`  in  M  word to enqueue
- `pop_valid`  out  1  `pop_data` holds the head word
- `pop_ready`  in  1  consumer takes the head this cycle
- `pop_data`  out  M  head word (registered)
- `count`  out  N+2  words held: RAM entries plus the output register
- `ram_we`  out  1  to `ram_top` `we`
- `ram_adr`  out  N  to `ram_top` `adr`
- `ram_din`  out  M  to `ram_top` `din`
- `ram_dout`  in  M  from `ram_top` `dout`; RAM read latency is 1 clock

## Operation
- Internal state: `wr_ptr`, `rd_ptr` (N bits, wrap modulo 2^N), `ram_cnt` (N+1 bits, 0..2^N), `out_valid`, `out_data`, and FSM `IDLE`/`RD_WAIT`.
- `push` = `push_valid & push_ready`. `pop` = `pop_valid & pop_ready`. `out_free` = `!out_valid | pop`.
- Fetch issue: in `IDLE` with `ram_cnt>0 & out_free`:
  - drive `ram_adr=rd_ptr`, `ram_we=0`;
  - `rd_ptr++`, `ram_cnt--`;
  - go to `RD_WAIT`.
- `RD_WAIT`, always exactly 1 cycle:
  - capture `ram_dout` into `out_data` and set `out_valid=1` at the closing edge;
  - go to `IDLE`.
- Bypass: `push` in `IDLE` with `ram_cnt==0 & out_free` loads `push_data` straight into `out_data`. No RAM write.
- RAM write: any other `push` sets `ram_we=1`, `ram_adr=wr_ptr`, `wr_ptr++`, `ram_cnt++`.
- `push_ready = rst_n & (ram_cnt<2^N) & !fetch_issue`.
  - A fetch has priority over a write for the single RAM port.
  - `push_ready` may depend combinationally on `pop_ready`.
- A `pop` with no fetch and no bypass in the same cycle clears `out_valid`.
- `count = ram_cnt + out_valid`, updated every edge.
- `ram_din = push_data` at all times. When no fetch is issued, `ram_adr = wr_ptr`.
- Simultaneous push and pop while `ram_cnt==2^N`: the push is refused. The pop itself starts a fetch, so `push_ready=0` that cycle anyway.

## Timing
- Reset (`rst_n=0`) acts asynchronously and immediately:
  - pointers, `ram_cnt` and `count` = 0; `pop_valid=0`; `pop_data=0`; FSM = `IDLE`;
  - `push_ready=0`, `ram_we=0`, `ram_adr=0`.
- Reset mid-`RD_WAIT` drops the in-flight fetch.
- First `push_ready=1` appears in the first cycle with `rst_n=1`.
- Bypass latency: push accepted at edge E0 → `pop_valid=1` after E0.
- Latency through the RAM: fetch issued in the cycle ending at E1 → `pop_valid=1` after E2.
- Drain throughput from the RAM is one word per 2 cycles. Push throughput is 1 per cycle, except in fetch-issue cycles.
- The RAM write occurs at the acceptance edge, because `ram_we`/`ram_adr`/`ram_din` are combinational.
- A write during `RD_WAIT` is legal. `ram_dout` is sampled at that same edge and returns the fetched word.

## Test plan
- Reset, then push 32'hA with `pop_ready=0` → bypass; after 1 edge `pop_valid=1`, `pop_data=32'hA`, `count=1`, `ram_we` never high.
- Push 32'hA, 32'hFA12, 32'hFFFF, 32'hFFFFFFFF back-to-back, `pop_ready=0`:
  - 32'hA is bypassed;
  - RAM writes go to adr 0, 1, 2 with `ram_we=1`;
  - `count=4`.
- Then hold `pop_ready=1` → pops in order A, FA12, FFFF, FFFFFFFF; `pop_valid` high every other cycle after the first; final `count=0`.
- Fill: `pop_ready=0`, push 18 words 0..17 → exactly 17 accepted (16 RAM + 1 output); `push_ready=0` at `count=17`.
  - Then pop one → words drain in order, and 17 is refused and never appears.
  - Wrap check: refill through `wr_ptr` wrap at 15→0 and drain; order is preserved.
- Push and pop asserted every cycle for 40 cycles:
  - the output sequence equals the accepted sequence;
  - `ram_we` and a fetch are never in the same cycle;
  - `count` is always ≤ 17.
- `rst_n` pulsed low during `RD_WAIT` with `count=5` → `pop_valid=0`, `count=0`, `ram_we=0` immediately; the next push (32'hF) is bypassed and popped as 32'hF.
